pipe_exe_md: RTL

Parametrised execute stage for the pipelined CPU. It keeps the single-cycle ALU/JAL path and adds an iterative unsigned multiply/divide unit that stalls the front of the pipeline while it runs. The block sits between the ID/EXE and EXE/MEM pipeline registers. Its estall output is ORed into the existing stall logic that freezes PC, IF/ID and ID/EXE.

---
 rtl/pipe_exe_md.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pipe_exe_md.sv
// rtl/pipe_exe_md.sv - execute stage with single-cycle ALU/JAL path and iterative unsigned multiply/divide
module pipe_exe_md #(
    parameter  int WIDTH = 32,
    parameter  int RNW   = 5,
    localparam int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [3:0]       ealuc,
    input  logic             ealuimm,
    input  logic             eshift,
    input  logic             ejal,
    input  logic             emd_req,
    input  logic [1:0]       emd_op,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic [WIDTH-1:0] eimm,
    input  logic [WIDTH-1:0] epc4,
    input  logic [WIDTH-1:0] esa,
    input  logic [RNW-1:0]   ern0,
    output logic [RNW-1:0]   ern,
    output logic [WIDTH-1:0] ealu,
    output logic             estall,
    output logic             edz
);

    localparam int SAW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [CNTW-1:0]    cnt;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [RNW-1:0]     rn_l;
    logic [1:0]         op_l;

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   s;
    logic [SAW-1:0]     sa;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     dsh;
    logic [WIDTH:0]     ddiff;
    logic [2*WIDTH-1:0] acc_step;
    logic               md_done;

    assign a  = eshift ? esa : ea;
    assign b  = ealuimm ? eimm : eb;
    assign sa = a[SAW-1:0];

    always_comb begin
        s = '0;
        casez (ealuc)
            4'b?000: s = a + b;
            4'b?100: s = a - b;
            4'b?001: s = a & b;
            4'b?101: s = a | b;
            4'b?010: s = a ^ b;
            4'b?110: s = b << (WIDTH / 2);
            4'b?011: s = b << sa;
            4'b0111: s = b >> sa;
            4'b1111: s = $unsigned($signed(b) >>> sa);
            default: s = '0;
        endcase
    end

    // acc holds {hi, lo}: product halves for MULU, {remainder, quotient} for DIVU
    always_comb begin
        msum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        dsh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ddiff = dsh - {1'b0, opnd};
        if (!op_l[1])
            acc_step = {msum, acc[WIDTH-1:1]};
        else if (!ddiff[WIDTH])
            acc_step = {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_step = {dsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            opnd  <= '0;
            acc   <= '0;
            rn_l  <= '0;
            op_l  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (emd_req) begin
                        state <= BUSY;
                        cnt   <= CNTW'(WIDTH);
                        opnd  <= emd_op[1] ? b : a;
                        acc   <= {{WIDTH{1'b0}}, (emd_op[1] ? a : b)};
                        rn_l  <= ern0;
                        op_l  <= emd_op;
                    end
                end
                BUSY: begin
                    acc <= acc_step;
                    cnt <= cnt - CNTW'(1);
                    if (cnt == CNTW'(1))
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign md_done = (state == DONE);
    assign estall  = (state == BUSY) || ((state == IDLE) && emd_req);
    assign ealu    = md_done ? (op_l[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0])
                             : (ejal ? epc4 : s);
    assign ern     = md_done ? rn_l : (ern0 | {RNW{ejal}});
    assign edz     = md_done && op_l[1] && (opnd == '0);

endmodule
